// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment reader: active-low segment patterns,
// special BCD codes and the frame FSM state type.
package seven_seg_pkg;

   // Segment order is {a, b, c, d, e, f, g}; a low bit lights the segment.
   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] BCD_BLANK = 4'hF;
   localparam logic [3:0] BCD_ERR   = 4'hE;

   typedef enum logic {
      COLLECT,
      PRESENT
   } frame_state_e;

endpackage

// File: rtl/seven_segment_pattern_decode.sv
// Combinational inverse of the BCD-to-segment decoder: maps an active-low
// segment pattern back to a BCD digit, flagging blank and illegal patterns.
module seven_segment_pattern_decode (
   input  logic [6:0] seg_i,
   output logic [3:0] bcd_o,
   output logic       blank_o,
   output logic       err_o
);
   import seven_seg_pkg::*;

   always_comb begin
      bcd_o   = BCD_ERR;
      blank_o = 1'b0;
      err_o   = 1'b0;
      case (seg_i)
         SEG_0:     bcd_o = 4'd0;
         SEG_1:     bcd_o = 4'd1;
         SEG_2:     bcd_o = 4'd2;
         SEG_3:     bcd_o = 4'd3;
         SEG_4:     bcd_o = 4'd4;
         SEG_5:     bcd_o = 4'd5;
         SEG_6:     bcd_o = 4'd6;
         SEG_7:     bcd_o = 4'd7;
         SEG_8:     bcd_o = 4'd8;
         SEG_9:     bcd_o = 4'd9;
         SEG_BLANK: begin
            bcd_o   = BCD_BLANK;
            blank_o = 1'b1;
         end
         default:   err_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/seven_segment_reader.sv
// Reads a multiplexed active-low seven-segment bus back into BCD frames and
// presents each complete frame over a valid/ready handshake.
module seven_segment_reader #(
   parameter int unsigned NUM_DIGITS    = 4,
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              seg_in,
   input  logic [NUM_DIGITS-1:0]   an_in,
   output logic [4*NUM_DIGITS-1:0] out_bcd,
   output logic [NUM_DIGITS-1:0]   out_blank,
   output logic [NUM_DIGITS-1:0]   out_err,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    overrun
);
   import seven_seg_pkg::*;

   localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned SW = NUM_DIGITS + 7;

   logic [SW-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [4*NUM_DIGITS-1:0] work_bcd_q, work_bcd_d, out_bcd_q, out_bcd_d, cap_bcd;
   logic [NUM_DIGITS-1:0]   work_blank_q, work_blank_d, out_blank_q, out_blank_d, cap_blank;
   logic [NUM_DIGITS-1:0]   work_err_q, work_err_d, out_err_q, out_err_d, cap_err;
   logic [NUM_DIGITS-1:0]   mask_q, mask_d, cap_mask;
   logic                    overrun_q, overrun_d;
   frame_state_e            state_q, state_d;

   logic [NUM_DIGITS-1:0] an_s, sel;
   logic [6:0]            seg_s;
   logic                  same, onehot, capture, complete;
   logic [3:0]            dec_bcd;
   logic                  dec_blank, dec_err;

   assign an_s  = sync2_q[SW-1:7];
   assign seg_s = sync2_q[6:0];
   assign sel   = ~an_s;

   seven_segment_pattern_decode u_decode (
      .seg_i   (seg_s),
      .bcd_o   (dec_bcd),
      .blank_o (dec_blank),
      .err_o   (dec_err)
   );

   // Stability tracking: one capture strobe per stable run of a one-hot anode.
   always_comb begin
      sync1_d = {an_in, seg_in};
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      same    = (sync2_q == prev_q);
      onehot  = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
      capture = same && (cnt_q == CW'(STABLE_CYCLES - 1)) && onehot;
      if (!same) begin
         cnt_d = CW'(1);
      end else if (cnt_q != CW'(STABLE_CYCLES)) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Working set with the current capture merged in, so the completing slot
   // reaches the output registers on the same edge.
   always_comb begin
      cap_bcd   = work_bcd_q;
      cap_blank = work_blank_q;
      cap_err   = work_err_q;
      cap_mask  = mask_q;
      if (capture) begin
         for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (sel[k]) begin
               cap_bcd[4*k +: 4] = dec_bcd;
               cap_blank[k]      = dec_blank;
               cap_err[k]        = dec_err;
               cap_mask[k]       = 1'b1;
            end
         end
      end
      complete = capture && (cap_mask == '1);
   end

   always_comb begin
      state_d      = state_q;
      work_bcd_d   = cap_bcd;
      work_blank_d = cap_blank;
      work_err_d   = cap_err;
      mask_d       = cap_mask;
      out_bcd_d    = out_bcd_q;
      out_blank_d  = out_blank_q;
      out_err_d    = out_err_q;
      overrun_d    = 1'b0;
      unique case (state_q)
         COLLECT: begin
            if (complete) begin
               out_bcd_d   = cap_bcd;
               out_blank_d = cap_blank;
               out_err_d   = cap_err;
               mask_d      = '0;
               state_d     = PRESENT;
            end
         end
         PRESENT: begin
            if (complete) begin
               mask_d = '0;
               if (out_ready) begin
                  out_bcd_d   = cap_bcd;
                  out_blank_d = cap_blank;
                  out_err_d   = cap_err;
               end else begin
                  overrun_d = 1'b1;
               end
            end else if (out_ready) begin
               state_d = COLLECT;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q      <= '1;
         sync2_q      <= '1;
         prev_q       <= '1;
         cnt_q        <= '0;
         work_bcd_q   <= '0;
         work_blank_q <= '0;
         work_err_q   <= '0;
         mask_q       <= '0;
         out_bcd_q    <= '0;
         out_blank_q  <= '0;
         out_err_q    <= '0;
         overrun_q    <= 1'b0;
         state_q      <= COLLECT;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         prev_q       <= prev_d;
         cnt_q        <= cnt_d;
         work_bcd_q   <= work_bcd_d;
         work_blank_q <= work_blank_d;
         work_err_q   <= work_err_d;
         mask_q       <= mask_d;
         out_bcd_q    <= out_bcd_d;
         out_blank_q  <= out_blank_d;
         out_err_q    <= out_err_d;
         overrun_q    <= overrun_d;
         state_q      <= state_d;
      end
   end

   assign out_bcd   = out_bcd_q;
   assign out_blank = out_blank_q;
   assign out_err   = out_err_q;
   assign out_valid = (state_q == PRESENT);
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Self-checking bench for seven_segment_reader: expected frames are pushed to a
// scoreboard when driven and popped when the DUT presents a frame.
module tb_seven_segment_reader;

   logic        clk;
   logic        rst_n;
   logic [6:0]  seg_in;
   logic [3:0]  an_in;
   logic [15:0] out_bcd;
   logic [3:0]  out_blank;
   logic [3:0]  out_err;
   logic        out_valid;
   logic        out_ready;
   logic        overrun;

   typedef struct packed {
      logic [15:0] bcd;
      logic [3:0]  blank;
      logic [3:0]  err;
   } frame_t;

   frame_t sb[$];
   frame_t exp_f;
   int     n_checks = 0;
   int     n_fail   = 0;
   int     ov_cnt   = 0;
   int     cap_cnt  = 0;

   seven_segment_reader #(
      .NUM_DIGITS    (4),
      .STABLE_CYCLES (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .seg_in    (seg_in),
      .an_in     (an_in),
      .out_bcd   (out_bcd),
      .out_blank (out_blank),
      .out_err   (out_err),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Independent reference table: returns {bcd, blank, err}.
   function automatic logic [5:0] ref_dec(input logic [6:0] s);
      case (s)
         7'b0000001: return {4'd0, 2'b00};
         7'b1001111: return {4'd1, 2'b00};
         7'b0010010: return {4'd2, 2'b00};
         7'b0000110: return {4'd3, 2'b00};
         7'b1001100: return {4'd4, 2'b00};
         7'b0100100: return {4'd5, 2'b00};
         7'b0100000: return {4'd6, 2'b00};
         7'b0001111: return {4'd7, 2'b00};
         7'b0000000: return {4'd8, 2'b00};
         7'b0000100: return {4'd9, 2'b00};
         7'b1111111: return {4'hF, 2'b10};
         default:    return {4'hE, 2'b01};
      endcase
   endfunction

   task automatic push_frame(input logic [6:0] s0, s1, s2, s3);
      logic [6:0] s [4];
      logic [5:0] r;
      frame_t     f;
      s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
      f = '0;
      for (int k = 0; k < 4; k++) begin
         r = ref_dec(s[k]);
         f.bcd[4*k +: 4] = r[5:2];
         f.blank[k]      = r[1];
         f.err[k]        = r[0];
      end
      sb.push_back(f);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (overrun === 1'b1) ov_cnt++;
      if (dut.capture === 1'b1) cap_cnt++;
   endtask

   task automatic drive_slot(input int k, input logic [6:0] s, input int n);
      logic [3:0] one;
      one    = 4'b0001;
      an_in  = ~(one << k);
      seg_in = s;
      repeat (n) tick();
   endtask

   task automatic drive_frame(input logic [6:0] s0, s1, s2, s3);
      drive_slot(0, s0, 6);
      drive_slot(1, s1, 6);
      drive_slot(2, s2, 6);
      drive_slot(3, s3, 6);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      n_checks++;
      if ({out_bcd, out_blank, out_err, out_valid, overrun} !== 26'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h required 0",
                  {out_bcd, out_blank, out_err, out_valid, overrun});
      end
      rst_n = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_static_slot();
      cap_cnt = 0;
      an_in   = 4'b1110;
      seg_in  = 7'b0010010;
      repeat (5) tick();
      n_checks++;
      if (dut.mask_q !== 4'b0000) begin
         n_fail++;
         $display("FAIL static_early: mask=%b required 0000 before edge 5", dut.mask_q);
      end
      tick();
      n_checks++;
      if (dut.mask_q !== 4'b0001 || dut.work_bcd_q[3:0] !== 4'd2) begin
         n_fail++;
         $display("FAIL static_capture: mask=%b bcd=%h required 0001/2",
                  dut.mask_q, dut.work_bcd_q[3:0]);
      end
      repeat (4) tick();
      n_checks++;
      if (cap_cnt !== 1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL static_once: captures=%0d valid=%b required 1/0", cap_cnt, out_valid);
      end
   endtask

   task automatic test_full_frame();
      push_frame(7'b0000110, 7'b1001100, 7'b0100000, 7'b0000100);
      drive_frame(7'b0000110, 7'b1001100, 7'b0100000, 7'b0000100);
      for (int i = 0; i < 40 && out_valid !== 1'b1; i++) tick();
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL full_valid: out_valid=%b required 1", out_valid);
      end
      exp_f = sb.pop_front();
      n_checks++;
      if ({out_bcd, out_blank, out_err} !== exp_f || out_bcd !== 16'h9643) begin
         n_fail++;
         $display("FAIL full_data: got %h required %h", {out_bcd, out_blank, out_err}, exp_f);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL full_handshake: out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_blank_err_glitch();
      push_frame(7'b0000001, 7'b1111111, 7'b1111110, 7'b1001111);
      drive_slot(0, 7'b0000001, 6);
      drive_slot(1, 7'b1111111, 6);
      drive_slot(2, 7'b1111110, 6);
      drive_slot(3, 7'b1001111, 3);
      an_in = 4'b1111;
      repeat (6) tick();
      n_checks++;
      if (out_valid !== 1'b0 || dut.mask_q !== 4'b0111) begin
         n_fail++;
         $display("FAIL glitch_ignored: valid=%b mask=%b required 0/0111", out_valid, dut.mask_q);
      end
      drive_slot(3, 7'b1001111, 6);
      for (int i = 0; i < 40 && out_valid !== 1'b1; i++) tick();
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL blank_valid: out_valid=%b required 1", out_valid);
      end
      exp_f = sb.pop_front();
      n_checks++;
      if ({out_bcd, out_blank, out_err} !== exp_f) begin
         n_fail++;
         $display("FAIL blank_err_data: got %h required %h", {out_bcd, out_blank, out_err}, exp_f);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      push_frame(7'b0100100, 7'b0001111, 7'b0000000, 7'b0000001);
      drive_frame(7'b0100100, 7'b0001111, 7'b0000000, 7'b0000001);
      for (int i = 0; i < 40 && out_valid !== 1'b1; i++) tick();
      exp_f = sb.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || {out_bcd, out_blank, out_err} !== exp_f) begin
         n_fail++;
         $display("FAIL bp_first: valid=%b data=%h required 1/%h",
                  out_valid, {out_bcd, out_blank, out_err}, exp_f);
      end
      ov_cnt = 0;
      drive_frame(7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100);
      repeat (5) tick();
      n_checks++;
      if (ov_cnt !== 1) begin
         n_fail++;
         $display("FAIL bp_overrun: pulses=%0d required 1", ov_cnt);
      end
      n_checks++;
      if (out_valid !== 1'b1 || {out_bcd, out_blank, out_err} !== exp_f) begin
         n_fail++;
         $display("FAIL bp_hold: valid=%b data=%h required 1/%h",
                  out_valid, {out_bcd, out_blank, out_err}, exp_f);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release: out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_invalid_anodes();
      cap_cnt = 0;
      an_in   = 4'b1111;
      seg_in  = 7'b0000001;
      repeat (20) tick();
      an_in = 4'b1100;
      repeat (20) tick();
      n_checks++;
      if (cap_cnt !== 0 || dut.mask_q !== 4'b0000 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL invalid_anode: captures=%0d mask=%b valid=%b required 0/0000/0",
                  cap_cnt, dut.mask_q, out_valid);
      end
   endtask

   task automatic test_reset_mid_frame();
      push_frame(7'b0000000, 7'b0000110, 7'b0100100, 7'b1001111);
      drive_frame(7'b0000000, 7'b0000110, 7'b0100100, 7'b1001111);
      for (int i = 0; i < 40 && out_valid !== 1'b1; i++) tick();
      exp_f = sb.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || {out_bcd, out_blank, out_err} !== exp_f) begin
         n_fail++;
         $display("FAIL rst_pre_frame: valid=%b data=%h required 1/%h",
                  out_valid, {out_bcd, out_blank, out_err}, exp_f);
      end
      drive_slot(0, 7'b0010010, 6);
      drive_slot(1, 7'b0000110, 6);
      n_checks++;
      if (dut.mask_q !== 4'b0011) begin
         n_fail++;
         $display("FAIL rst_partial: mask=%b required 0011", dut.mask_q);
      end
      an_in = 4'b1111;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n_checks++;
      if ({out_bcd, out_blank, out_err, out_valid, overrun} !== 26'd0
          || dut.mask_q !== 4'b0000) begin
         n_fail++;
         $display("FAIL rst_mid: outputs=%h mask=%b required 0/0000",
                  {out_bcd, out_blank, out_err, out_valid, overrun}, dut.mask_q);
      end
      push_frame(7'b0001111, 7'b1001100, 7'b0100000, 7'b0000001);
      drive_slot(0, 7'b0001111, 6);
      drive_slot(1, 7'b1001100, 6);
      drive_slot(2, 7'b0100000, 6);
      repeat (4) tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_needs_all: out_valid=%b required 0", out_valid);
      end
      drive_slot(3, 7'b0000001, 6);
      for (int i = 0; i < 40 && out_valid !== 1'b1; i++) tick();
      exp_f = sb.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || {out_bcd, out_blank, out_err} !== exp_f) begin
         n_fail++;
         $display("FAIL rst_next_frame: valid=%b data=%h required 1/%h",
                  out_valid, {out_bcd, out_blank, out_err}, exp_f);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b0;
      an_in     = 4'b1111;
      seg_in    = 7'b1111111;
      test_reset();
      test_static_slot();
      test_full_frame();
      test_blank_err_glitch();
      test_backpressure();
      test_invalid_anodes();
      test_reset_mid_frame();
      n_checks++;
      if (sb.size() !== 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: %0d entries left, required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
